testframe_generator: RTL

GMII-side test traffic source for the interconnect tester. It emits Ethernet test frames with preamble/SFD, a 36-octet header template, the 0x00 0x07 testframe marker at data octets 36/37, and zero padding. The frame ends with a trailer of sequence number, TX timestamp and CRC-32 FCS. It is the transmit counterpart of the analyzer's testframe parser: a frame it emits is recognised and decoded by that parser unchanged.

---
 rtl/testframe_generator_if.sv | 10 +
 rtl/testframe_generator.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/testframe_generator_if.sv
// GMII transmit bus between the test frame source and its sink.
// The source drives octets; the sink only observes them.
interface testframe_generator_if;
  logic [7:0] d;
  logic       en;
  logic       er;

  modport master (output d, en, er);
  modport slave  (input d, en, er);
endinterface

// File: rtl/testframe_generator.sv
// GMII test frame source: preamble, header, marker, padding,
// trailer (seq, timestamps) and CRC-32 FCS, in bursts.
module testframe_generator #(
  parameter int MIN_FRAME_SIZE = 64,
  parameter int MAX_FRAME_SIZE = 9600,
  parameter int MIN_IFG        = 12
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   start,
  input  logic                   stop,
  input  logic [31:0]            frame_count,
  input  logic [13:0]            frame_size,
  input  logic [15:0]            ifg,
  input  logic [287:0]           header_data,
  input  logic [47:0]            timestamp_sec,
  input  logic [31:0]            timestamp_nsec,
  testframe_generator_if.master  gmii,
  output logic                   busy,
  output logic [31:0]            frames_sent
);

  localparam logic [13:0] MINF = 14'(MIN_FRAME_SIZE);
  localparam logic [13:0] MAXF = 14'(MAX_FRAME_SIZE);
  localparam logic [15:0] MINI = 16'(MIN_IFG);

  typedef enum logic [2:0] {
    IDLE, PRE, DATA, FCS, IFG
  } state_t;

  state_t       state_q, state_d;
  logic [15:0]  cnt_q, cnt_d;
  logic [13:0]  size_q;
  logic [15:0]  ifg_q;
  logic [31:0]  fc_q, burst_q;
  logic         stop_q;
  logic [63:0]  seq_q, seq_lat_q;
  logic [47:0]  sec_q;
  logic [31:0]  nsec_q;
  logic [31:0]  crc_q;
  logic [7:0]   d_q, d_d;
  logic         en_q, en_d;
  logic         busy_q;
  logic [31:0]  sent_q;

  logic [13:0]  size_cl;
  logic [15:0]  ifg_cl;
  logic [15:0]  last_k, trl_k;
  logic [15:0]  k_d, toff;
  logic [143:0] trailer;
  logic [7:0]   data_oct;
  logic [1:0]   fcs_j;
  logic         done;

  function automatic logic [31:0] crc8(
    input logic [31:0] c,
    input logic [7:0]  b
  );
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    end
    return r;
  endfunction

  assign size_cl = (frame_size < MINF) ? MINF :
                   (frame_size > MAXF) ? MAXF : frame_size;
  assign ifg_cl  = (ifg < MINI) ? MINI : ifg;
  assign last_k  = {2'b00, size_q} - 16'd5;
  assign trl_k   = {2'b00, size_q} - 16'd22;
  assign trailer = {seq_lat_q, sec_q, nsec_q};
  assign fcs_j   = cnt_q[1:0] + 2'd1;
  assign done    = stop_q | stop |
                   ((fc_q != 32'd0) && (burst_q == fc_q));

  // Octet that the next cycle carries when it is a data octet.
  always_comb begin
    k_d      = (state_q == DATA) ? cnt_q + 16'd1 : 16'd0;
    toff     = k_d - trl_k;
    data_oct = 8'h00;
    unique case (1'b1)
      k_d < 16'd36:
        data_oct = header_data[{k_d[5:0], 3'b000} +: 8];
      k_d == 16'd37:
        data_oct = 8'h07;
      k_d >= trl_k:
        data_oct = trailer[8'd136 - {toff[4:0], 3'b000} +: 8];
      default:
        data_oct = 8'h00;
    endcase
  end

  // Next state and the registered GMII octet it produces.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    d_d     = 8'h00;
    en_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = PRE;
          cnt_d   = 16'd0;
          d_d     = 8'h55;
          en_d    = 1'b1;
        end
      end
      PRE: begin
        en_d = 1'b1;
        if (cnt_q == 16'd7) begin
          state_d = DATA;
          cnt_d   = 16'd0;
          d_d     = data_oct;
        end else begin
          cnt_d = cnt_q + 16'd1;
          d_d   = (cnt_q == 16'd6) ? 8'hD5 : 8'h55;
        end
      end
      DATA: begin
        en_d = 1'b1;
        if (cnt_q == last_k) begin
          state_d = FCS;
          cnt_d   = 16'd0;
          d_d     = ~crc_q[7:0];
        end else begin
          cnt_d = cnt_q + 16'd1;
          d_d   = data_oct;
        end
      end
      FCS: begin
        if (cnt_q == 16'd3) begin
          state_d = IFG;
          cnt_d   = 16'd0;
        end else begin
          en_d  = 1'b1;
          cnt_d = cnt_q + 16'd1;
          d_d   = ~crc_q[{fcs_j, 3'b000} +: 8];
        end
      end
      IFG: begin
        if (cnt_q == ifg_q - 16'd1) begin
          if (done) begin
            state_d = IDLE;
          end else begin
            state_d = PRE;
            cnt_d   = 16'd0;
            d_d     = 8'h55;
            en_d    = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, outputs, burst parameters, counters and running CRC.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      size_q    <= MINF;
      ifg_q     <= MINI;
      fc_q      <= '0;
      burst_q   <= '0;
      stop_q    <= 1'b0;
      seq_q     <= '0;
      seq_lat_q <= '0;
      sec_q     <= '0;
      nsec_q    <= '0;
      crc_q     <= '1;
      d_q       <= '0;
      en_q      <= 1'b0;
      busy_q    <= 1'b0;
      sent_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      d_q     <= d_d;
      en_q    <= en_d;
      if (state_q == IDLE && start) begin
        fc_q    <= frame_count;
        size_q  <= size_cl;
        ifg_q   <= ifg_cl;
        burst_q <= '0;
        busy_q  <= 1'b1;
        stop_q  <= stop;
      end else if (busy_q && stop) begin
        stop_q <= 1'b1;
      end
      if (state_q == IFG && state_d == IDLE) begin
        busy_q <= 1'b0;
        stop_q <= 1'b0;
      end
      if (state_q == PRE && cnt_q == 16'd6) begin
        sec_q     <= timestamp_sec;
        nsec_q    <= timestamp_nsec;
        seq_lat_q <= seq_q;
      end
      if (state_q == FCS && cnt_q == 16'd2) begin
        sent_q  <= sent_q + 32'd1;
        seq_q   <= seq_q + 64'd1;
        burst_q <= burst_q + 32'd1;
      end
      if (state_d == DATA) begin
        crc_q <= crc8(crc_q, d_d);
      end else if (state_d == PRE) begin
        crc_q <= '1;
      end
    end
  end

  assign gmii.d      = d_q;
  assign gmii.en     = en_q;
  assign gmii.er     = 1'b0;
  assign busy        = busy_q;
  assign frames_sent = sent_q;

endmodule
